reg_bank: RTL



---
 rtl/reg_bank.sv | 67 ++++++
 1 files changed

// File: rtl/reg_bank.sv
// ============================================================================
//  Module   : reg_bank
//  Purpose  : 32 x DATA_W MIPS register file, two combinational read ports,
//             one clocked write port; r0 hardwired to zero, r29 resets to
//             SP_RESET. Optional macro REG_BANK_BYPASS_EN enables write-first
//             forwarding on the read ports.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_bank #(
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int          NUM_REGS = 32;
    localparam logic [4:0]  SP_ADDR  = 5'd29;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Writes to address 0 are dropped here so r0 keeps its reset value of 0.
    always_comb begin
        regs_d = regs_q;
        if (reg_write && (write_reg != 5'd0)) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (5'(i) == SP_ADDR) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        read_data1 = (read_reg1 == 5'd0) ? '0 : regs_q[read_reg1];
        read_data2 = (read_reg2 == 5'd0) ? '0 : regs_q[read_reg2];
`ifdef REG_BANK_BYPASS_EN
        // Forward in-flight write data so a same-cycle reader sees the new value.
        if (reg_write && (write_reg != 5'd0) && (read_reg1 == write_reg)) begin
            read_data1 = write_data;
        end
        if (reg_write && (write_reg != 5'd0) && (read_reg2 == write_reg)) begin
            read_data2 = write_data;
        end
`else
`endif
    end

endmodule

`default_nettype wire
